memory_unit: RTL and testbench



---
 rtl/memory_unit.sv | 102 ++++++++++
 tb/tb_memory_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Memory address register plus 16x8 RAM on the shared bus, with a
// valid/ready program loader that fills the RAM before the CPU runs.
module memory_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              clr,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              mar_load,
    input  logic              ram_write,
    input  logic              ram_out_en,
    input  logic              prog_mode,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar_q
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic cpu_idle;
    logic load_we;
    logic cpu_we;

    assign cpu_idle = (state_q == IDLE) && !clr;
    assign load_we  = (state_q == LOAD) && prog_mode && prog_valid && !clr;
    assign cpu_we   = cpu_idle && ram_write && !ram_out_en;

    assign bus = (cpu_idle && ram_out_en) ? mem[mar_q] : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            mar_q      <= '0;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mar_load) begin
                        mar_q <= bus[ADDR_W-1:0];
                    end
                    if (prog_mode) begin
                        state_q    <= LOAD;
                        ptr_q      <= '0;
                        prog_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    // Leaving LOAD wins over a byte offered on the same edge.
                    if (!prog_mode) begin
                        state_q    <= IDLE;
                        prog_ready <= 1'b0;
                    end else if (prog_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == LAST) begin
                            state_q    <= DONE;
                            ptr_q      <= '0;
                            prog_ready <= 1'b0;
                            prog_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!prog_mode) begin
                        state_q   <= IDLE;
                        prog_done <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    prog_ready <= 1'b0;
                    prog_done  <= 1'b0;
                end
            endcase
        end
    end

    // RAM is deliberately not reset; contents survive clr.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[ptr_q] <= prog_data;
        end else if (cpu_we) begin
            mem[mar_q] <= bus;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: CPU-side vectors, loader sequences,
// async reset corners; bus reads go through an expected-value queue.
module tb_memory_unit;

    logic       clk = 1'b0;
    logic       clr;
    wire  [7:0] bus;
    logic       mar_load, ram_write, ram_out_en;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_done;
    logic [3:0] mar_q;

    logic [7:0] drv;
    logic       drv_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [4];

    assign bus = drv_en ? drv : 8'hzz;

    // A released bus reads back as all ones.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus[g]);
    end

    memory_unit dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .mar_load   (mar_load),
        .ram_write  (ram_write),
        .ram_out_en (ram_out_en),
        .prog_mode  (prog_mode),
        .prog_data  (prog_data),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .mar_q      (mar_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [7:0] a);
        drv      = a;
        drv_en   = 1'b1;
        mar_load = 1'b1;
        step();
        mar_load = 1'b0;
        drv_en   = 1'b0;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        set_mar({4'h0, a});
        drv       = d;
        drv_en    = 1'b1;
        ram_write = 1'b1;
        step();
        ram_write = 1'b0;
        drv_en    = 1'b0;
    endtask

    task automatic read_addr(input logic [3:0] a, input logic [7:0] exp,
                             input string nm);
        logic [7:0] e;
        set_mar({4'hA, a});
        ram_out_en = 1'b1;
        sb.push_back(exp);
        #3;
        e = sb.pop_front();
        chk(nm, {24'h0, bus}, {24'h0, e});
        ram_out_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rc;
        int acc;

        vecs[0] = '{addr: 4'h3, data: 8'h5A};
        vecs[1] = '{addr: 4'h8, data: 8'hC3};
        vecs[2] = '{addr: 4'hC, data: 8'h01};
        vecs[3] = '{addr: 4'h0, data: 8'h7E};

        clr = 1'b1;
        {mar_load, ram_write, ram_out_en} = 3'b000;
        {prog_mode, prog_valid} = 2'b00;
        prog_data = 8'h00;
        drv = 8'h00;
        drv_en = 1'b0;
        #12 clr = 1'b0;
        step();

        #3;
        chk("reset mar", {28'h0, mar_q}, 32'h0);
        chk("reset ready", {31'h0, prog_ready}, 32'h0);
        chk("reset done", {31'h0, prog_done}, 32'h0);
        chk("reset bus", {24'h0, bus}, 32'hFF);

        set_mar(8'hF9);
        #3;
        chk("mar upper bits ignored", {28'h0, mar_q}, 32'h9);
        step();
        #2 clr = 1'b1;
        #1;
        chk("async clr mar", {28'h0, mar_q}, 32'h0);
        chk("async clr bus", {24'h0, bus}, 32'hFF);
        step();
        clr = 1'b0;
        step();

        foreach (vecs[i]) cpu_write(vecs[i].addr, vecs[i].data);
        foreach (vecs[i]) read_addr(vecs[i].addr, vecs[i].data, "vec read");

        cpu_write(4'hB, 8'hA5);
        read_addr(4'hB, 8'hA5, "cpu read A5");
        chk("mar B", {28'h0, mar_q}, 32'hB);
        drv        = 8'h3C;
        drv_en     = 1'b1;
        ram_write  = 1'b1;
        ram_out_en = 1'b1;
        step();
        ram_write = 1'b0;
        drv_en    = 1'b0;
        sb.push_back(8'hA5);
        #3;
        chk("write suppressed", {24'h0, bus}, {24'h0, sb.pop_front()});
        ram_out_en = 1'b0;

        set_mar(8'h02);
        drv       = 8'h07;
        drv_en    = 1'b1;
        mar_load  = 1'b1;
        ram_write = 1'b1;
        step();
        {mar_load, ram_write, drv_en} = 3'b000;
        #3;
        chk("simul mar", {28'h0, mar_q}, 32'h7);
        read_addr(4'h2, 8'h07, "simul ram2");

        // Full load, valid held high.
        prog_mode  = 1'b1;
        prog_valid = 1'b1;
        prog_data  = 8'h10;
        step();
        rc = 0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            prog_data = 8'h10 + 8'(acc);
            #3;
            if (!prog_ready) break;
            rc++;
            step();
            acc++;
        end
        chk("full ready cycles", rc, 32'd16);
        chk("full done", {31'h0, prog_done}, 32'h1);
        step();
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        step();
        #3;
        chk("done drops", {31'h0, prog_done}, 32'h0);
        for (int a = 0; a < 16; a++)
            read_addr(4'(a), 8'h10 + 8'(a), "full readback");

        // Alternating valid.
        prog_mode = 1'b1;
        step();
        rc = 0;
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            prog_valid = (i % 2 == 0);
            prog_data  = 8'h40 + 8'(acc);
            #3;
            if (!prog_ready) break;
            rc++;
            step();
            if (i % 2 == 0) acc++;
        end
        chk("gap ready cycles", rc, 32'd31);
        chk("gap done", {31'h0, prog_done}, 32'h1);
        step();
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        step();
        for (int a = 0; a < 16; a++)
            read_addr(4'(a), 8'h40 + 8'(a), "gap readback");

        // Abort after 5 bytes; CPU controls ignored while loading.
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            prog_data = 8'h60 + 8'(i);
            step();
        end
        prog_valid = 1'b0;
        drv        = 8'h03;
        drv_en     = 1'b1;
        mar_load   = 1'b1;
        step();
        mar_load   = 1'b0;
        drv_en     = 1'b0;
        ram_out_en = 1'b1;
        #3;
        chk("load mar held", {28'h0, mar_q}, 32'hF);
        chk("load bus Z", {24'h0, bus}, 32'hFF);
        chk("load ready", {31'h0, prog_ready}, 32'h1);
        ram_out_en = 1'b0;
        prog_data  = 8'h99;
        prog_valid = 1'b1;
        prog_mode  = 1'b0;
        step();
        prog_valid = 1'b0;
        #3;
        chk("abort ready", {31'h0, prog_ready}, 32'h0);
        for (int a = 0; a < 5; a++)
            read_addr(4'(a), 8'h60 + 8'(a), "abort readback");
        read_addr(4'h5, 8'h45, "abort addr5 kept");

        // clr mid-load with prog_mode held.
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prog_data = 8'h80 + 8'(i);
            step();
        end
        prog_valid = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("clr ready async", {31'h0, prog_ready}, 32'h0);
        step();
        clr = 1'b0;
        step();
        #3;
        chk("reenter load", {31'h0, prog_ready}, 32'h1);
        prog_valid = 1'b1;
        prog_data  = 8'h90;
        step();
        prog_data  = 8'h91;
        step();
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        step();
        read_addr(4'h0, 8'h90, "reload addr0");
        read_addr(4'h1, 8'h91, "reload addr1");
        for (int a = 2; a < 6; a++)
            read_addr(4'(a), 8'h80 + 8'(a), "kept after clr");
        read_addr(4'h6, 8'h46, "addr6 untouched");

        chk("scoreboard empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
